// File: rtl/accel_req2apb_bridge_pkg.sv
// Shared types and helpers for the request-to-APB bridge.
// The optional APB watchdog is enabled by defining ACCEL_REQ2APB_TIMEOUT_EN.
package accel_req2apb_bridge_pkg;

  // NSLV is at most 16, so a 4-bit slave index always suffices.
  localparam int unsigned SlvIdxBits = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  // Width-independent control state of one beat in flight.
  typedef struct packed {
    state_e                 state;
    logic [SlvIdxBits-1:0]  idx;    // decoded slave
    logic [2:0]             lane;   // start lane L
    logic [2:0]             k;      // current sub-transfer
    logic [3:0]             num;    // sub-transfer count n
    logic                   write;
    logic                   err;    // sticky error accumulator
  } ctrl_t;

  localparam ctrl_t CtrlReset = '{
    state: StIdle,
    idx:   '0,
    lane:  '0,
    k:     '0,
    num:   '0,
    write: 1'b0,
    err:   1'b0
  };

  // Start lane of a beat: APB word index of the address within the request word.
  function automatic logic [2:0] lane_of(input logic [15:0]  addr_lo,
                                         input int unsigned  req_bytes,
                                         input int unsigned  apb_bytes);
    int unsigned off;
    off = 32'(addr_lo) % req_bytes;
    return 3'(off / apb_bytes);
  endfunction

  // Number of APB transfers for a beat: at least one, never past the top lane.
  function automatic logic [3:0] xfer_count(input logic [7:0]   size,
                                            input logic [2:0]   lane,
                                            input int unsigned  apb_bytes,
                                            input int unsigned  lanes);
    int unsigned n;
    n = (32'(size) + apb_bytes - 1) / apb_bytes;
    if (n == 0) n = 1;
    if (n > lanes - 32'(lane)) n = lanes - 32'(lane);
    return 4'(n);
  endfunction

endpackage

// File: rtl/accel_apb_addr_decoder.sv
// Combinational address decoder over base/mask windows; lowest index wins on overlap.
module accel_apb_addr_decoder
  import accel_req2apb_bridge_pkg::*;
#(
  parameter int unsigned               NSLV      = 4,
  parameter int unsigned               ADDR_BITS = 32,
  parameter logic [NSLV*ADDR_BITS-1:0] SLV_BASE  = '0,
  parameter logic [NSLV*ADDR_BITS-1:0] SLV_MASK  = '0
) (
  input  logic [ADDR_BITS-1:0]  addr,
  output logic                  hit,
  output logic [SlvIdxBits-1:0] idx
);

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_BITS +: ADDR_BITS]) == SLV_BASE[i*ADDR_BITS +: ADDR_BITS]) begin
        hit = 1'b1;
        idx = SlvIdxBits'(i);
      end
    end
  end

endmodule

// File: rtl/accel_req2apb_bridge.sv
// Request-beat to APB bridge: splits one wide beat into 1..R APB transfers.
// Optional APB watchdog: define ACCEL_REQ2APB_TIMEOUT_EN.
module accel_req2apb_bridge
  import accel_req2apb_bridge_pkg::*;
#(
  parameter int unsigned               NSLV           = 4,
  parameter int unsigned               ADDR_BITS      = 32,
  parameter int unsigned               REQ_DATA_BITS  = 64,
  parameter int unsigned               APB_DATA_BITS  = 32,
  parameter logic [NSLV*ADDR_BITS-1:0] SLV_BASE       = {32'h0000_0000, 32'h0000_3000,
                                                         32'h0000_2000, 32'h0000_1000},
  parameter logic [NSLV*ADDR_BITS-1:0] SLV_MASK       = {32'hFFFF_0000, 32'hFFFF_F000,
                                                         32'hFFFF_F000, 32'hFFFF_F000},
  parameter int unsigned               TIMEOUT_CYCLES = 255
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR_BITS-1:0]         i_req_addr,
  input  logic [7:0]                   i_req_size,
  input  logic                         i_req_write,
  input  logic [REQ_DATA_BITS-1:0]     i_req_wdata,
  input  logic [REQ_DATA_BITS/8-1:0]   i_req_wstrb,
  input  logic                         i_req_last,
  output logic                         o_resp_valid,
  output logic [REQ_DATA_BITS-1:0]     o_resp_rdata,
  output logic                         o_resp_err,
  output logic [ADDR_BITS-1:0]         o_paddr,
  output logic                         o_pwrite,
  output logic [APB_DATA_BITS-1:0]     o_pwdata,
  output logic [APB_DATA_BITS/8-1:0]   o_pstrb,
  output logic [2:0]                   o_pprot,
  output logic [NSLV-1:0]              o_psel,
  output logic                         o_penable,
  input  logic [NSLV*APB_DATA_BITS-1:0] i_prdata,
  input  logic [NSLV-1:0]              i_pready,
  input  logic [NSLV-1:0]              i_pslverr
);

  localparam int unsigned ReqBytes = REQ_DATA_BITS / 8;
  localparam int unsigned ApbBytes = APB_DATA_BITS / 8;
  localparam int unsigned Lanes    = REQ_DATA_BITS / APB_DATA_BITS;
  localparam int unsigned ApbOff   = $clog2(ApbBytes);

  ctrl_t                      ctrl_q, ctrl_d;
  logic [ADDR_BITS-1:0]       base_q, base_d;
  logic [REQ_DATA_BITS-1:0]   wdata_q, wdata_d;
  logic [ReqBytes-1:0]        wstrb_q, wstrb_d;
  logic [REQ_DATA_BITS-1:0]   rdata_q, rdata_d;

  logic                       dec_hit;
  logic [SlvIdxBits-1:0]      dec_idx;
  logic [2:0]                 start_lane;
  logic [2:0]                 cur;
  logic                       in_xfer;
  logic [NSLV-1:0]            sel;
  logic [APB_DATA_BITS-1:0]   prdata_sel;
  logic                       pready_sel;
  logic                       pslverr_sel;

  // Burst framing is the upstream adapter's concern; every beat stands alone.
  logic unused_cfg;
  assign unused_cfg = i_req_last ^ (TIMEOUT_CYCLES == 0);

  accel_apb_addr_decoder #(
    .NSLV      (NSLV),
    .ADDR_BITS (ADDR_BITS),
    .SLV_BASE  (SLV_BASE),
    .SLV_MASK  (SLV_MASK)
  ) u_decoder (
    .addr (i_req_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign start_lane = lane_of(16'(i_req_addr), ReqBytes, ApbBytes);
  assign cur        = ctrl_q.lane + ctrl_q.k;
  assign in_xfer    = (ctrl_q.state == StSetup) || (ctrl_q.state == StAccess);

  // Select the addressed slave's response lines; others are ignored.
  always_comb begin
    sel         = '0;
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (ctrl_q.idx == SlvIdxBits'(i)) begin
        sel[i]      = 1'b1;
        prdata_sel  = i_prdata[i*APB_DATA_BITS +: APB_DATA_BITS];
        pready_sel  = i_pready[i];
        pslverr_sel = i_pslverr[i];
      end
    end
  end

`ifdef ACCEL_REQ2APB_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
`endif

  // Next-state logic: beat capture, sub-transfer sequencing and read accumulation.
  always_comb begin
    ctrl_d  = ctrl_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
`ifdef ACCEL_REQ2APB_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (ctrl_q.state)
      StIdle: begin
        if (i_req_valid) begin
          base_d       = i_req_addr & ~ADDR_BITS'(ApbBytes - 1);
          wdata_d      = i_req_wdata;
          wstrb_d      = i_req_wstrb;
          ctrl_d.write = i_req_write;
          ctrl_d.idx   = dec_idx;
          ctrl_d.lane  = start_lane;
          ctrl_d.k     = '0;
          ctrl_d.num   = xfer_count(i_req_size, start_lane, ApbBytes, Lanes);
          if (dec_hit) begin
            rdata_d      = '0;
            ctrl_d.err   = 1'b0;
            ctrl_d.state = StSetup;
          end else begin
            rdata_d      = '1;
            ctrl_d.err   = 1'b1;
            ctrl_d.state = StResp;
          end
        end
      end
      StSetup: begin
        ctrl_d.state = StAccess;
`ifdef ACCEL_REQ2APB_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      StAccess: begin
        if (pready_sel) begin
          rdata_d[cur*APB_DATA_BITS +: APB_DATA_BITS] = prdata_sel;
          ctrl_d.err = ctrl_q.err | pslverr_sel;
          if (({1'b0, ctrl_q.k} + 4'd1) < ctrl_q.num) begin
            ctrl_d.k     = ctrl_q.k + 3'd1;
            ctrl_d.state = StSetup;
          end else begin
            ctrl_d.state = StResp;
          end
        end
`ifdef ACCEL_REQ2APB_TIMEOUT_EN
        else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // Give up on the slave: poison this lane and skip the rest.
          rdata_d[cur*APB_DATA_BITS +: APB_DATA_BITS] = '1;
          ctrl_d.err   = 1'b1;
          ctrl_d.state = StResp;
        end else begin
          timer_d = timer_q + 16'd1;
        end
`endif
      end
      StResp: begin
        rdata_d      = '0;
        ctrl_d.err   = 1'b0;
        ctrl_d.state = StIdle;
      end
      default: ctrl_d.state = StIdle;
    endcase
  end

  // State registers; APB outputs decode from state, so reset drops them at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ctrl_q  <= CtrlReset;
      base_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef ACCEL_REQ2APB_TIMEOUT_EN
  // Watchdog counter for the access phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`endif

  assign o_req_ready  = (ctrl_q.state == StIdle);
  assign o_resp_valid = (ctrl_q.state == StResp);
  assign o_resp_rdata = o_resp_valid ? rdata_q : '0;
  assign o_resp_err   = o_resp_valid & ctrl_q.err;
  assign o_psel       = in_xfer ? sel : '0;
  assign o_penable    = (ctrl_q.state == StAccess);
  assign o_paddr      = in_xfer ? base_q + (ADDR_BITS'(ctrl_q.k) << ApbOff) : '0;
  assign o_pwrite     = in_xfer & ctrl_q.write;
  assign o_pwdata     = in_xfer ? wdata_q[cur*APB_DATA_BITS +: APB_DATA_BITS] : '0;
  assign o_pstrb      = in_xfer ? wstrb_q[cur*ApbBytes +: ApbBytes] : '0;
  assign o_pprot      = 3'b000;

endmodule
